// File: rtl/mem_byte_ctrl.sv
// ============================================================================
// mem_byte_ctrl : serialises byte/half/word loads and stores onto an 8-bit RAM
// Optional alignment trap enabled by MEM_MISALIGN_CHK_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_byte_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_m,
  input  logic [1:0]        rvalid_bit,
  input  logic [31:0]       raddr_m,
  output logic [31:0]       rdata_m,
  input  logic              we_m,
  input  logic [1:0]        wvalid_bit,
  input  logic [31:0]       waddr_m,
  input  logic [31:0]       wdata_m,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        size_q, size_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              st_req, ld_req, req_valid, req_mis;
  logic [2:0]        last_k;
  logic [2:0]        cap_k;
  logic [ADDR_W-1:0] beat_addr;
  logic [31:0]       wshift;
  logic              unused_addr_hi;

  assign st_req    = we_m && (wvalid_bit != 2'b00);
  assign ld_req    = re_m && (rvalid_bit != 2'b00);
  assign req_valid = st_req || ld_req;
  assign stall_req = !rst && req_valid && (state_q != S_DONE);

  // Index of the final beat: 0, 1 or 3 for byte, half, word.
  assign last_k    = {1'b0, size_q[1] & size_q[0], size_q[1]};
  assign cap_k     = cnt_q - 3'd1;
  assign beat_addr = addr_q + ADDR_W'(cnt_q);
  assign wshift    = wdata_q >> {cnt_q[1:0], 3'b000};
  assign rdata_m   = rdata_q;
  assign unused_addr_hi = ^{raddr_m[31:ADDR_W], waddr_m[31:ADDR_W]};

`ifdef MEM_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  function automatic logic is_mis(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == 2'b10) && a[0]) || ((sz == 2'b11) && (a != 2'b00));
  endfunction

  assign req_mis      = st_req ? is_mis(wvalid_bit, waddr_m[1:0])
                               : is_mis(rvalid_bit, raddr_m[1:0]);
  assign misalign_d   = misalign_q || ((state_q == S_IDLE) && req_valid && req_mis);
  assign misalign_err = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign req_mis      = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_addr    = ram_addr_q;
    ram_wdata   = ram_wdata_q;
    ram_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        if (st_req) begin
          addr_d  = waddr_m[ADDR_W-1:0];
          wdata_d = wdata_m;
          size_d  = wvalid_bit;
          state_d = req_mis ? S_DONE : S_WR;
        end else if (ld_req) begin
          addr_d  = raddr_m[ADDR_W-1:0];
          size_d  = rvalid_bit;
          asm_d   = 32'd0;
          state_d = S_DONE;
          if (req_mis) rdata_d = 32'd0;
          else         state_d = S_RD;
        end
      end
      S_WR: begin
        ram_addr    = beat_addr;
        ram_wdata   = wshift[7:0];
        ram_we      = 1'b1;
        ram_addr_d  = beat_addr;
        ram_wdata_d = wshift[7:0];
        cnt_d       = cnt_q + 3'd1;
        if (cnt_q == last_k) state_d = S_DONE;
      end
      S_RD: begin
        if (cnt_q <= last_k) begin
          ram_addr   = beat_addr;
          ram_addr_d = beat_addr;
        end
        // Data for the address issued last beat arrives now.
        if (cnt_q != 3'd0) asm_d[{cap_k[1:0], 3'b000} +: 8] = ram_rdata;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == last_k + 3'd1) begin
          rdata_d = asm_d;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      rdata_q     <= 32'd0;
      size_q      <= 2'b00;
      cnt_q       <= 3'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_byte_ctrl.sv
// ============================================================================
// tb_mem_byte_ctrl : directed self-checking bench with a behavioural byte RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_byte_ctrl;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              re_m, we_m;
  logic [1:0]        rvalid_bit, wvalid_bit;
  logic [31:0]       raddr_m, waddr_m, wdata_m;
  logic [31:0]       rdata_m;
  logic              stall_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              misalign_err;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  int total  = 0;
  int passed = 0;

  int          stalls, wes;
  logic [31:0] rd, fa, fw;

  always #5 clk = ~clk;

  mem_byte_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .re_m(re_m), .rvalid_bit(rvalid_bit), .raddr_m(raddr_m), .rdata_m(rdata_m),
    .we_m(we_m), .wvalid_bit(wvalid_bit), .waddr_m(waddr_m), .wdata_m(wdata_m),
    .stall_req(stall_req), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .misalign_err(misalign_err)
  );

  // Synchronous RAM: registered read, one cycle latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request and run it to DONE; counts stalled cycles after capture.
  task automatic xact(input logic st, input logic ld, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] data,
                      output int n_stall, output int n_we,
                      output logic [31:0] rdat, output logic [31:0] first_a,
                      output logic [31:0] first_w);
    logic done;
    @(negedge clk);
    we_m = st; wvalid_bit = st ? sz : 2'b00; waddr_m = addr; wdata_m = data;
    re_m = ld; rvalid_bit = ld ? sz : 2'b00; raddr_m = addr;
    n_stall = 0; n_we = 0; done = 1'b0; first_a = '0; first_w = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!stall_req) done = 1'b1;
      else begin
        if (n_stall == 0) begin
          first_a = 32'(ram_addr);
          first_w = 32'(ram_wdata);
        end
        n_stall++;
        if (ram_we) n_we++;
      end
    end
    rdat = rdata_m;
    check("done_reached", 32'(done), 32'd1);
    we_m = 1'b0; wvalid_bit = 2'b00; re_m = 1'b0; rvalid_bit = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    re_m = 1'b0; we_m = 1'b0; rvalid_bit = 2'b00; wvalid_bit = 2'b00;
    raddr_m = '0; waddr_m = '0; wdata_m = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rdata", rdata_m, 32'd0);
    check("rst_mis", 32'(misalign_err), 32'd0);
    rst = 1'b0;

    // SW 0x11223344 @ 0x100
    xact(1'b1, 1'b0, 2'b11, 32'h100, 32'h11223344, stalls, wes, rd, fa, fw);
    check("sw_stalls", stalls, 4);
    check("sw_we_cycles", wes, 4);
    check("sw_first_addr", fa, 32'h100);
    check("sw_first_byte", fw, 32'h44);
    check("sw_mem", {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]}, 32'h11223344);
    check("sw_rdata_kept", rd, 32'd0);

    // LW @ 0x100
    xact(1'b0, 1'b1, 2'b11, 32'h100, 32'h0, stalls, wes, rd, fa, fw);
    check("lw_stalls", stalls, 5);
    check("lw_we_cycles", wes, 0);
    check("lw_rdata", rd, 32'h11223344);

    // SB 0xAB @ 0x101, LH @ 0x100, LB @ 0x103
    xact(1'b1, 1'b0, 2'b01, 32'h101, 32'hFFFFFFAB, stalls, wes, rd, fa, fw);
    check("sb_stalls", stalls, 1);
    check("sb_rdata_kept", rd, 32'h11223344);
    xact(1'b0, 1'b1, 2'b10, 32'h100, 32'h0, stalls, wes, rd, fa, fw);
    check("lh_stalls", stalls, 3);
    check("lh_rdata", rd, 32'h0000AB44);
    xact(1'b0, 1'b1, 2'b01, 32'h103, 32'h0, stalls, wes, rd, fa, fw);
    check("lb_stalls", stalls, 2);
    check("lb_rdata", rd, 32'h00000011);

    // Address wrap at the top of the RAM
    xact(1'b1, 1'b0, 2'b11, 32'h1FFFF, 32'hDEADBEEF, stalls, wes, rd, fa, fw);
    check("wrap_first_addr", fa, 32'h1FFFF);
    check("wrap_b0", 32'(mem[32'h1FFFF]), 32'hEF);
    check("wrap_b123", {8'h00, mem[2], mem[1], mem[0]}, 32'h00DEADBE);

    // Store and load together: store wins
    xact(1'b1, 1'b1, 2'b01, 32'h10, 32'h00000055, stalls, wes, rd, fa, fw);
    check("both_we_cycles", wes, 1);
    check("both_mem", 32'(mem[32'h10]), 32'h55);
    check("both_rdata_kept", rd, 32'h00000011);

    // Misaligned word load @ 0x102 (bytes 0x104/0x105 set up first)
    xact(1'b1, 1'b0, 2'b10, 32'h104, 32'h00006655, stalls, wes, rd, fa, fw);
    xact(1'b0, 1'b1, 2'b11, 32'h102, 32'h0, stalls, wes, rd, fa, fw);
`ifdef MEM_MISALIGN_CHK_EN
    check("mis_stalls", stalls, 0);
    check("mis_we_cycles", wes, 0);
    check("mis_rdata", rd, 32'd0);
    check("mis_err", 32'(misalign_err), 32'd1);
    xact(1'b0, 1'b1, 2'b01, 32'h100, 32'h0, stalls, wes, rd, fa, fw);
    check("mis_err_sticky", 32'(misalign_err), 32'd1);
`else
    check("mis_stalls", stalls, 5);
    check("mis_rdata", rd, 32'h66551122);
    check("mis_err", 32'(misalign_err), 32'd0);
`endif

    // Reset during RD beat 2 of a word load
    @(negedge clk);
    re_m = 1'b1; rvalid_bit = 2'b11; raddr_m = 32'h100;
    repeat (3) @(negedge clk);
    check("mid_rd_stall", 32'(stall_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_stall", 32'(stall_req), 32'd0);
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_addr", 32'(ram_addr), 32'd0);
    check("abort_rdata", rdata_m, 32'd0);
    check("abort_mis", 32'(misalign_err), 32'd0);
    re_m = 1'b0; rvalid_bit = 2'b00;
    rst = 1'b0;

    // Controller is back in IDLE and serves a fresh load
    xact(1'b0, 1'b1, 2'b01, 32'h100, 32'h0, stalls, wes, rd, fa, fw);
    check("post_rst_stalls", stalls, 2);
    check("post_rst_rdata", rd, 32'h00000044);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
